// File: rtl/clock_divider.sv
// clock_divider: enable-gated rate divider producing a one-cycle `flag`
// strobe every DIV enabled clock cycles. The strobe is meant to be used
// as a clock-enable tick by slower downstream logic.
module clock_divider #(
  parameter int DIV   = 6,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic s_rst,
  input  logic enable,
  output logic flag
);

  // Terminal count; reaching it on an enabled edge wraps the counter and fires the strobe.
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // Counter and strobe register: async reset, then sync clear, then enabled counting, else hold.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
      flag  <= 1'b0;
    end else if (s_rst) begin
      count <= '0;
      flag  <= 1'b0;
    end else if (enable) begin
      if (count == LAST_COUNT) begin
        count <= '0;
        flag  <= 1'b1;
      end else begin
        count <= count + ONE;
        flag  <= 1'b0;
      end
    end else begin
      flag  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: scoreboard bench for clock_divider. The stimulus side
// predicts each flag value from a count of enabled edges since the last clear
// and queues it; a separate monitor pops and compares after every rising edge
// and after every asynchronous reset assertion.
`timescale 1ns/10ps
module tb_clock_divider;

  localparam int DIV   = 6;
  localparam int CNT_W = 8;

  logic clk;
  logic n_rst;
  logic s_rst;
  logic enable;
  logic flag;

  typedef struct {
    logic  exp_flag;
    int    cycle;
    string label;
  } exp_t;

  exp_t sb_q[$];

  int    compared;
  int    mismatched;
  int    cycle_no;
  int    enabled_since_clear;
  string phase;
  event  async_ev;

  clock_divider #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .s_rst  (s_rst),
    .enable (enable),
    .flag   (flag)
  );

  // 150 MHz system clock.
  initial clk = 1'b0;
  always #3.33 clk = ~clk;

  // Reference model: flag rises after every DIV-th enabled edge counted since the last clear.
  function automatic logic predictFlag(input logic n, input logic s, input logic e);
    if (!n || s) begin
      enabled_since_clear = 0;
      return 1'b0;
    end
    if (e) begin
      enabled_since_clear++;
      return (enabled_since_clear % DIV) == 0;
    end
    return 1'b0;
  endfunction

  // Drive inputs for the next rising edge and queue the predicted flag.
  task automatic applyStimulus(input logic n, input logic s, input logic e);
    exp_t item;
    n_rst  = n;
    s_rst  = s;
    enable = e;
    cycle_no++;
    item.exp_flag = predictFlag(n, s, e);
    item.cycle    = cycle_no;
    item.label    = phase;
    sb_q.push_back(item);
  endtask

  task automatic stepCycle(input logic n, input logic s, input logic e);
    @(negedge clk);
    applyStimulus(n, s, e);
  endtask

  // Pull n_rst low between edges; flag must drop before the next rising edge.
  task automatic asyncReset(input logic s, input logic e);
    exp_t item;
    @(negedge clk);
    #0.5;
    n_rst = 1'b0;
    enabled_since_clear = 0;
    item.exp_flag = 1'b0;
    item.cycle    = cycle_no;
    item.label    = {phase, "_async"};
    sb_q.push_back(item);
    -> async_ev;
    #1.5;
    applyStimulus(1'b0, s, e);
  endtask

  task automatic checkOutput(input exp_t item, input logic actual);
    compared++;
    if (actual !== item.exp_flag) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: flag=%0b expected %0b",
               item.label, item.cycle, actual, item.exp_flag);
    end
  endtask

  // Monitor: sample just after each rising edge or async reset and compare against the queue head.
  initial begin
    exp_t item;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL scoreboard_underflow at %0t: flag=%0b expected an entry", $time, flag);
      end else begin
        item = sb_q.pop_front();
        checkOutput(item, flag);
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized run.
  initial begin
    exp_t item;
    compared            = 0;
    mismatched          = 0;
    cycle_no            = 0;
    enabled_since_clear = 0;
    phase               = "reset";
    n_rst  = 1'b1;
    s_rst  = 1'b0;
    enable = 1'b0;
    #0.5;
    n_rst = 1'b0;
    item.exp_flag = 1'b0;
    item.cycle    = 0;
    item.label    = "reset_async";
    sb_q.push_back(item);
    -> async_ev;
    #1.5;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) stepCycle(1'b0, 1'b0, 1'b0);

    phase = "sclear_hold";
    repeat (2) stepCycle(1'b1, 1'b1, 1'b0);

    phase = "steady20";
    repeat (20) stepCycle(1'b1, 1'b0, 1'b1);

    phase = "enable_gap";
    stepCycle(1'b1, 1'b1, 1'b0);
    repeat (3) stepCycle(1'b1, 1'b0, 1'b1);
    repeat (4) stepCycle(1'b1, 1'b0, 1'b0);
    repeat (8) stepCycle(1'b1, 1'b0, 1'b1);

    phase = "sclear_at4";
    stepCycle(1'b1, 1'b1, 1'b0);
    repeat (4) stepCycle(1'b1, 1'b0, 1'b1);
    stepCycle(1'b1, 1'b1, 1'b1);
    repeat (8) stepCycle(1'b1, 1'b0, 1'b1);

    phase = "async_at5";
    stepCycle(1'b1, 1'b1, 1'b0);
    repeat (5) stepCycle(1'b1, 1'b0, 1'b1);
    asyncReset(1'b0, 1'b1);
    repeat (8) stepCycle(1'b1, 1'b0, 1'b1);

    phase = "sclear_on_wrap";
    stepCycle(1'b1, 1'b1, 1'b0);
    repeat (5) stepCycle(1'b1, 1'b0, 1'b1);
    stepCycle(1'b1, 1'b1, 1'b1);
    repeat (14) stepCycle(1'b1, 1'b0, 1'b1);

    phase = "async_on_flag";
    stepCycle(1'b1, 1'b1, 1'b0);
    repeat (6) stepCycle(1'b1, 1'b0, 1'b1);
    asyncReset(1'b0, 1'b1);
    repeat (7) stepCycle(1'b1, 1'b0, 1'b1);

    phase = "random";
    for (int i = 0; i < 500; i++) begin
      int r;
      r = int'($urandom_range(99, 0));
      if (r < 2) begin
        asyncReset(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end else begin
        stepCycle(($urandom_range(99, 0) >= 2),
                  ($urandom_range(99, 0) < 5),
                  ($urandom_range(99, 0) < 70));
      end
    end

    @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Enable-gated clock-rate divider on the 150 MHz system clock (6.66 ns period).
- Emits a single-cycle strobe `flag` once every DIV enabled clock cycles.
- Downstream logic uses `flag` as a clock-enable tick for slower-rate processing.
- Has an asynchronous active-low reset plus a synchronous clear (`s_rst`) for the upstream controller.

Parameters:
- DIV, 6: division ratio. Enabled cycles between successive flag pulses. Legal range 1 to 2^CNT_W.
- CNT_W, 8: width of the internal cycle counter in bits.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- n_rst, input, 1: asynchronous active-low reset. Clears all state immediately.
- s_rst, input, 1: synchronous active-high clear. Sampled on the rising edge of clk.
- enable, input, 1: count enable. Counter advances only while high.
- flag, output, 1: registered divide strobe. High for exactly one clk cycle per DIV enabled cycles.

Behaviour:
- State consists of counter `count` [CNT_W-1:0] and output register `flag`.
- Reset (n_rst=0), asynchronous: count=0 and flag=0 immediately, held until n_rst=1. The first update is on the first rising edge after release.
- Priority at each rising edge: n_rst > s_rst > enable > hold.
- s_rst=1: count<=0 and flag<=0, regardless of enable.
- s_rst=0, enable=1, count==DIV-1: count<=0 (wrap) and flag<=1.
- s_rst=0, enable=1, count!=DIV-1: count<=count+1 and flag<=0.
- s_rst=0, enable=0: count holds its value and flag<=0. The flag strobe never stretches past one cycle.
- flag is a pure register output with no combinational path from any input.
- Latency from clear:
  - After s_rst (or n_rst) releases with enable held high, the first flag rises after the DIV-th enabled edge.
  - Thereafter flag is high one cycle in every DIV, giving duty 1/DIV.
- Gaps in enable stretch the period: flag fires on the DIV-th enabled edge counted since the last wrap or clear, not the DIV-th clock edge.
- DIV=1: flag stays high on every cycle following an enabled edge, i.e. continuously high while enable stays high.
- Counter never exceeds DIV-1. No overflow or wrap other than at DIV-1.
- s_rst asserted on the same edge a wrap would occur: the clear wins, count=0 and flag=0.
- n_rst asserted mid-count: immediate clear. Counting restarts from 0 after release.
- X/undriven inputs are not required to be handled.

Test Plan:
- Hold n_rst=0, then release with s_rst=1 and enable=0 for 2 edges -> flag=0 and count=0 throughout; no flag while s_rst=1.
- With DIV=6, drop s_rst to 0 and raise enable for 20 cycles -> flag high exactly after enabled edges 6, 12 and 18, one cycle each; low on all other cycles.
- Enable high for 3 edges, low for 4 edges, high again -> flag first rises after the 6th enabled edge, i.e. clock edge 10; no flag during the gap.
- Pulse s_rst for 1 cycle when count=4, with enable held high -> next flag occurs 6 enabled edges after s_rst drops, not 2.
- Assert n_rst=0 asynchronously between edges while count=5 -> flag and count go to 0 immediately; after release, the first flag appears after 6 enabled edges.
- Assert s_rst on the edge where count=5 and enable=1 -> flag stays 0 and count=0; the normal 6-cycle period resumes afterwards.
